ook_keyer: RTL and testbench
============================

# ook_keyer

- On-off-keying (OOK) frame generator that drives the RF gate.
- Sits directly upstream of the carrier gating: its `KEY` output replaces the free-running slow-counter bit as the signal ANDed with the carrier clock (`rf = carrier && KEY`).
- Accepts bytes over a valid/ready handshake and serialises each into a timed frame: start mark, 8 data bits LSB first, then a stop gap.
- Data bits are optionally Manchester-coded.

## Interface
Parameters:
- `BIT_DIV`, 12000: clock cycles per symbol; ≥ 2; must be even when `MANCHESTER` = 1.
- `STOP_BITS`, 2: number of symbol periods of key-off after the data bits; ≥ 1.
- `MANCHESTER`, 0: 1 = Manchester-code the data bits (1 → high then low half-symbols; 0 → low then high). The start mark and stop gap are never coded.

Ports:
- `CLK`  in  1  sole clock; the domain of the carrier's slow counter.
- `RST`  in  1  reset; synchronous, active-high.
- `in_data`  in  8  byte to transmit.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block can accept a byte.
- `abort`  in  1  synchronous pulse; kills the current frame.
- `KEY`  out  1  registered carrier gate; 1 = carrier on.
- `busy`  out  1  a frame is in progress.
- `sym_tick`  out  1  one-cycle pulse on the last cycle of each symbol.

## Operation
- **FSM states:** IDLE, START, DATA, STOP.
- **IDLE**
  - `in_ready`=1, `KEY`=0, `busy`=0.
  - On `in_valid && in_ready`: latch `in_data` into the shift register, clear the bit index and timer, go to START.
- **START:** `KEY`=1 for one symbol, then DATA.
- **DATA**
  - 8 symbols; the bit index runs 0..7 and each symbol sends shift-register bit 0.
  - The register shifts right at each symbol end.
  - Non-Manchester: `KEY` = bit for the whole symbol.
  - Manchester: `KEY` = bit for the first `BIT_DIV/2` cycles, then its complement.
  - After bit 7, go to STOP.
- **STOP:** `KEY`=0 for `STOP_BITS` symbols, then IDLE.
- **Symbol timer:** counts 0..`BIT_DIV-1` and wraps to 0. `sym_tick`=1 when count = `BIT_DIV-1` and the state is not IDLE. The timer is held at 0 in IDLE.
- **`in_ready`:** high only in IDLE. There is no internal buffering and `in_data` is ignored outside IDLE.
- **`abort`:** in any non-IDLE state, go to IDLE next edge: `KEY`=0, timer cleared, the byte is discarded and no stop gap is sent. Ignored in IDLE. If `abort` and `in_valid` are both high in IDLE, the byte is accepted.
- **`RST`:** wins over everything. Next edge: IDLE, `KEY`=0, `busy`=0, `in_ready`=1, `sym_tick`=0, timer=0, shift register=0. Applies mid-frame as well.
- **Width rules**
  - Timer width = `$clog2(BIT_DIV)`.
  - Stop counter width = `$clog2(STOP_BITS+1)`.
  - Bit index is 3 bits.
  - No counter may overflow: every counter is compared against its terminal value, never against a wrap.

## Timing
- Let t be the handshake edge.
- Start mark: `KEY`=1 on cycles t+1 .. t+`BIT_DIV`.
- Data bit i: occupies cycles t+1+(1+i)·`BIT_DIV` .. t+(2+i)·`BIT_DIV`.
- Stop gap: `KEY`=0 through cycle t+(9+`STOP_BITS`)·`BIT_DIV`.
- `in_ready` rises on cycle t+1+(9+`STOP_BITS`)·`BIT_DIV`.
- Back-to-back frame period: (9+`STOP_BITS`)·`BIT_DIV`+1 cycles.
- `KEY`, `busy`, `in_ready` and `sym_tick` are all registered; no combinational path from any input to any output.
- `busy` = (state ≠ IDLE), updated on the same edge as the state.

## Structure
- **Package `ook_pkg`:**
  - state enum (IDLE, START, DATA, STOP)
  - `DATA_BITS`=8
  - frame-length helper function (9+`STOP_BITS`)
- **Sub-module `ook_sym_timer`:**
  - parameter `BIT_DIV`; inputs `CLK`, `RST`, `run`.
  - Outputs: `sym_end` (count = `BIT_DIV-1`) and `half` (count ≥ `BIT_DIV/2`), the latter used for Manchester.
  - Counter clears when `run`=0.

## Test plan
Bench parameters: `BIT_DIV`=4, `STOP_BITS`=2, `MANCHESTER`=0 unless noted.
1. **Reset values:** assert `RST` 3 cycles with `in_valid`=1 → `KEY`=0, `busy`=0, `in_ready`=1 throughout; no frame starts until the first edge after `RST` falls.
2. **Single byte:** send 0xA5 → `KEY` over 44 cycles = start 1111, data 1111 0000 1111 0000 0000 1111 0000 1111, stop 00000000; `in_ready` returns on cycle 45; `sym_tick` fires 11 times.
3. **Back-to-back:** 0x00 then 0xFF with `in_valid` held → second start mark begins exactly 45 cycles after the first; `in_ready` high exactly 1 cycle between frames.
4. **Manchester:** `MANCHESTER`=1, send 0x01 → after the 4-cycle mark, bit 0 = 1100 and bits 1..7 = 0011 each, then 8 cycles of 0.
5. **Abort mid-frame:** send 0xFF, pulse `abort` during data bit 3 → `KEY`=0 and `busy`=0 on the next cycle, `in_ready`=1; a new byte 0x81 is accepted and framed correctly.
6. **Reset mid-frame:** pulse `RST` during stop → `KEY`=0, `busy`=0 next cycle; a byte held during `RST` is not accepted.

Source files
------------

// File: rtl/ook_keyer_pkg.sv
// ---------------------------------------------------------------------------
// ook_pkg: shared definitions for the OOK keyer.
//   ook_state_t  - frame sequencer states
//   DATA_BITS    - payload bits per frame
//   frame_syms() - symbols per frame (start + data + stop gap)
// No ports; imported by the keyer, its symbol timer and its interface.
// ---------------------------------------------------------------------------
package ook_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } ook_state_t;

  localparam int DATA_BITS = 8;

  // One start mark, the payload, then the stop gap.
  function automatic int frame_syms(input int stop_bits);
    return 1 + DATA_BITS + stop_bits;
  endfunction

endpackage

// File: rtl/ook_keyer_if.sv
// ---------------------------------------------------------------------------
// ook_keyer_if: byte handshake into the OOK keyer.
//   in_data  - byte to transmit (source -> keyer)
//   in_valid - in_data is valid   (source -> keyer)
//   in_ready - keyer can accept   (keyer -> source)
// A byte transfers on any clock edge where in_valid && in_ready.
// ---------------------------------------------------------------------------
interface ook_keyer_if;
  import ook_pkg::*;

  logic [DATA_BITS-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/ook_keyer_sym_timer.sv
// ---------------------------------------------------------------------------
// ook_sym_timer: symbol-period counter for the OOK keyer.
//   CLK, RST - clock, synchronous active-high reset
//   run      - 1 = keep counting, 0 = clear the count on the next edge
//   sym_end  - the count about to be loaded is BIT_DIV-1 (last cycle of a symbol)
//   half     - the count about to be loaded is >= BIT_DIV/2 (Manchester 2nd half)
//
// Both flags describe the count the counter takes on the coming edge, so the
// keyer can register its outputs and still have them line up with the count
// that is live in that cycle.
// ---------------------------------------------------------------------------
module ook_sym_timer
  import ook_pkg::*;
#(
  parameter int BIT_DIV = 12000
) (
  input  logic CLK,
  input  logic RST,
  input  logic run,
  output logic sym_end,
  output logic half
);

  localparam int            TW        = $clog2(BIT_DIV);
  localparam logic [TW-1:0] CNT_LAST  = TW'(BIT_DIV - 1);
  localparam logic [TW-1:0] CNT_HALF  = TW'(BIT_DIV / 2);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  // Wrap is an explicit compare against the terminal count, never an overflow.
  always_comb begin
    cnt_d = '0;
    if (run && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sym_end = (cnt_d == CNT_LAST);
  assign half    = (cnt_d >= CNT_HALF);

endmodule

// File: rtl/ook_keyer.sv
// ---------------------------------------------------------------------------
// ook_keyer: on-off-keying frame generator driving the RF carrier gate.
// Each accepted byte becomes: one symbol of key-on (start mark), 8 data
// symbols LSB first (optionally Manchester coded), then STOP_BITS symbols of
// key-off. Downstream gating is rf = carrier && KEY.
//
// Ports:
//   CLK      - sole clock
//   RST      - synchronous active-high reset, overrides everything
//   in_if    - byte handshake (slave side): in_data / in_valid / in_ready
//   abort    - synchronous pulse; drops the current frame, no stop gap
//   KEY      - registered carrier gate, 1 = carrier on
//   busy     - registered, a frame is in progress
//   sym_tick - registered one-cycle pulse on the last cycle of each symbol
//
// Every output is a flop loaded from next-state values, so each output is
// valid in the same cycle as the state it describes and no input reaches an
// output combinationally.
// ---------------------------------------------------------------------------
module ook_keyer
  import ook_pkg::*;
#(
  parameter int BIT_DIV    = 12000,
  parameter int STOP_BITS  = 2,
  parameter int MANCHESTER = 0
) (
  input  logic        CLK,
  input  logic        RST,
  ook_keyer_if.slave  in_if,
  input  logic        abort,
  output logic        KEY,
  output logic        busy,
  output logic        sym_tick
);

  localparam int            SW        = $clog2(STOP_BITS + 1);
  localparam logic [SW-1:0] STOP_LAST = SW'(STOP_BITS - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

  ook_state_t           state_q, state_d;
  logic [2:0]           bit_q,   bit_d;
  logic [SW-1:0]        stop_q,  stop_d;
  logic [DATA_BITS-1:0] sr_q,    sr_d;

  logic key_q,   key_d;
  logic busy_q,  busy_d;
  logic ready_q, ready_d;
  logic tick_q,  tick_d;

  logic run;
  logic tm_end;
  logic tm_half;

  // tick_q is high exactly on the last cycle of a symbol while framing, so it
  // doubles as the sequencer's symbol-end strobe.
  ook_sym_timer #(
    .BIT_DIV (BIT_DIV)
  ) u_timer (
    .CLK     (CLK),
    .RST     (RST),
    .run     (run),
    .sym_end (tm_end),
    .half    (tm_half)
  );

  // ---- next state -----------------------------------------------------------
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    sr_d    = sr_q;

    case (state_q)
      IDLE: begin
        if (in_if.in_valid) begin
          sr_d    = in_if.in_data;
          bit_d   = '0;
          stop_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (tick_q) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick_q) begin
          sr_d = sr_q >> 1;
          if (bit_q == BIT_LAST) begin
            stop_d  = '0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (tick_q) begin
          if (stop_q == STOP_LAST) begin
            state_d = IDLE;
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort only matters mid-frame; in IDLE a simultaneous byte is accepted.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      sr_d    = '0;
    end
  end

  // Timer holds at 0 in IDLE and is cleared on the edge that leaves a frame,
  // so it also sits at 0 on the first cycle of every new frame.
  assign run = (state_q != IDLE) && (state_d != IDLE);

  // ---- output decode (registered below) -------------------------------------
  always_comb begin
    key_d   = 1'b0;
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
    tick_d  = tm_end && (state_d != IDLE);

    case (state_d)
      START:   key_d = 1'b1;
      // Manchester inverts the bit for the second half of the symbol.
      DATA:    key_d = sr_d[0] ^ ((MANCHESTER != 0) && tm_half);
      default: key_d = 1'b0;
    endcase
  end

  // ---- register stage -------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      bit_q   <= '0;
      stop_q  <= '0;
      sr_q    <= '0;
      key_q   <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      sr_q    <= sr_d;
      key_q   <= key_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      tick_q  <= tick_d;
    end
  end

  assign KEY            = key_q;
  assign busy           = busy_q;
  assign sym_tick       = tick_q;
  assign in_if.in_ready = ready_q;

endmodule

// File: tb/tb_ook_keyer.sv
// ---------------------------------------------------------------------------
// tb_ook_keyer: two keyers (plain and Manchester) share one stimulus stream.
// The reference model turns each accepted byte into the full expected KEY
// waveform (a queue of per-cycle values) straight from the frame rules; the
// bench pops one value per clock and compares KEY, busy, in_ready and
// sym_tick of both instances every cycle, plus directed whole-frame checks.
// ---------------------------------------------------------------------------
module tb_ook_keyer;
  import ook_pkg::*;

  localparam int B     = 4;
  localparam int SB    = 2;
  localparam int FRAME = (9 + SB) * B;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       abort = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] data  = 8'h00;

  logic key_p, busy_p, tick_p;
  logic key_m, busy_m, tick_m;

  ook_keyer_if if_p ();
  ook_keyer_if if_m ();

  assign if_p.in_data  = data;
  assign if_p.in_valid = valid;
  assign if_m.in_data  = data;
  assign if_m.in_valid = valid;

  ook_keyer #(.BIT_DIV(B), .STOP_BITS(SB), .MANCHESTER(0)) dut_p (
    .CLK(clk), .RST(rst), .in_if(if_p), .abort(abort),
    .KEY(key_p), .busy(busy_p), .sym_tick(tick_p)
  );

  ook_keyer #(.BIT_DIV(B), .STOP_BITS(SB), .MANCHESTER(1)) dut_m (
    .CLK(clk), .RST(rst), .in_if(if_m), .abort(abort),
    .KEY(key_m), .busy(busy_m), .sym_tick(tick_m)
  );

  always #5 clk = ~clk;

  int   vectors = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   hs_cyc  = 0;
  logic hs_seen = 1'b0;
  bit   qp[$];
  bit   qm[$];

  task automatic check(input string tag, input logic got, input logic exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected KEY waveform of one frame, cycle by cycle.
  function automatic void build(input logic [7:0] b);
    qp.delete();
    qm.delete();
    for (int c = 0; c < B; c++) begin
      qp.push_back(1'b1);
      qm.push_back(1'b1);
    end
    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < B; c++) begin
        qp.push_back(b[i]);
        qm.push_back((c < B / 2) ? b[i] : !b[i]);
      end
    end
    for (int c = 0; c < SB * B; c++) begin
      qp.push_back(1'b0);
      qm.push_back(1'b0);
    end
  endfunction

  // One clock: advance the model on the edge, then compare all outputs.
  task automatic tick();
    int  k;
    logic inframe;
    hs_seen = 1'b0;
    @(posedge clk);
    cyc++;
    if (rst) begin
      qp.delete();
      qm.delete();
    end else if (qp.size() != 0) begin
      if (abort) begin
        qp.delete();
        qm.delete();
      end else begin
        void'(qp.pop_front());
        void'(qm.pop_front());
      end
    end else if (valid) begin
      build(data);
      hs_seen = 1'b1;
      hs_cyc  = cyc;
    end
    #1;
    inframe = (qp.size() != 0);
    k = FRAME - qp.size();
    check("key_plain", key_p, inframe ? qp[0] : 1'b0);
    check("key_manch", key_m, inframe ? qm[0] : 1'b0);
    check("busy_plain", busy_p, inframe);
    check("busy_manch", busy_m, inframe);
    check("ready_plain", if_p.in_ready, !inframe);
    check("ready_manch", if_m.in_ready, !inframe);
    check("tick_plain", tick_p, inframe && ((k % B) == B - 1));
    check("tick_manch", tick_m, inframe && ((k % B) == B - 1));
  endtask

  task automatic send(input logic [7:0] b);
    data  = b;
    valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (hs_seen) break;
    end
    check("handshake", hs_seen, 1'b1);
    valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((qp.size() != 0) && (n < 200)) begin
      tick();
      n++;
    end
    check("idle_reached", busy_p, 1'b0);
  endtask

  // Call right after send(): records the frame from its first cycle.
  task automatic capture(output logic [FRAME-1:0] cp, output logic [FRAME-1:0] cm,
                         output int nt);
    cp = '0;
    cm = '0;
    nt = 0;
    for (int k = 0; k < FRAME; k++) begin
      if (k != 0) tick();
      cp = {cp[FRAME-2:0], key_p};
      cm = {cm[FRAME-2:0], key_m};
      nt += int'(tick_p);
    end
  endtask

  initial begin
    logic [FRAME-1:0] cp, cm;
    int               nt, h1, rdy;
    logic [7:0]       b;

    // Reset held with a byte offered: nothing may start while RST is high.
    rst   = 1'b1;
    valid = 1'b1;
    data  = 8'h5A;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("start_after_rst", busy_p, 1'b1);
    valid = 1'b0;
    wait_idle();

    // Single byte 0xA5, whole waveform and tick count.
    send(8'hA5);
    capture(cp, cm, nt);
    check_vec("frame_a5_plain", 64'(cp), 64'(44'hFF0F00F0F00));
    check_vec("frame_a5_manch", 64'(cm), 64'(44'hFC3C33C3C00));
    check_vec("ticks_a5", 64'(nt), 64'd11);
    tick();
    check("ready_return", if_p.in_ready, 1'b1);

    // Back-to-back 0x00 then 0xFF with valid held.
    data  = 8'h00;
    valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (hs_seen) break;
    end
    h1    = hs_cyc;
    data  = 8'hFF;
    rdy   = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (hs_seen) break;
      if (if_p.in_ready) rdy++;
    end
    valid = 1'b0;
    check("b2b_second_hs", hs_seen, 1'b1);
    check_vec("b2b_period", 64'(hs_cyc - h1), 64'(FRAME + 1));
    check_vec("b2b_ready_cycles", 64'(rdy), 64'd1);
    wait_idle();

    // Manchester shape of 0x01.
    send(8'h01);
    capture(cp, cm, nt);
    check_vec("frame_01_plain", 64'(cp), 64'(44'hFF000000000));
    check_vec("frame_01_manch", 64'(cm), 64'(44'hFC333333300));
    tick();

    // Abort during data bit 3, then a clean 0x81 frame.
    send(8'hFF);
    repeat (17) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_key", key_p, 1'b0);
    check("abort_busy", busy_p, 1'b0);
    check("abort_ready", if_p.in_ready, 1'b1);
    send(8'h81);
    capture(cp, cm, nt);
    check_vec("frame_81_plain", 64'(cp), 64'(44'hFF000000F00));
    check_vec("frame_81_manch", 64'(cm), 64'(44'hFC333333C00));
    tick();

    // Abort while idle is ignored: the byte is still taken.
    abort = 1'b1;
    send(8'h3C);
    abort = 1'b0;
    check("idle_abort_accept", busy_p, 1'b1);
    wait_idle();

    // Reset during the stop gap, with a byte held through reset.
    send(8'hC3);
    repeat (40) tick();
    rst   = 1'b1;
    valid = 1'b1;
    data  = 8'h55;
    tick();
    check("rst_key", key_m, 1'b0);
    check("rst_busy", busy_m, 1'b0);
    tick();
    rst   = 1'b0;
    valid = 1'b0;
    tick();
    check("rst_no_accept", busy_p, 1'b0);

    // Randomised frames with occasional aborts and idle gaps.
    for (int n = 0; n < 12; n++) begin
      b = 8'($urandom);
      repeat ($urandom_range(0, 3)) tick();
      send(b);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(0, FRAME - 2)) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
      end
      wait_idle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
